alu_cmp_mux_enum: RTL and testbench
===================================

Name: alu_cmp_mux_enum

Overview:
- Execute-stage datapath of the RISC-V core, together with the operation encodings it consumes: ALU op (ALU_OP_ENUM), operand mux select (ALU_MUX_ENUM) and branch compare op (ALU_CMP_OP_ENUM).
- Selects the ALU operands (rs1 or pc, rs2 or immediate) and computes the ALU result.
- Evaluates the branch condition on rs1/rs2 and drives a 2-bit next-PC select to the fetch stage.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  core clock. Present for pipeline uniformity; the datapath is combinational.
- rst_n  in  1  asynchronous, active-high reset. Name kept per codebase; asserted = 1.
- rs1_data  in  XLEN  register source 1.
- rs2_data  in  XLEN  register source 2.
- immediate  in  XLEN  sign-extended immediate.
- pc  in  XLEN  PC of the instruction.
- alu_op  in  4  ALU_OP_ENUM code.
- alu_data1_sel  in  1  ALU_MUX_ENUM: D1_RS1=0, D1_PC=1.
- alu_data2_sel  in  1  ALU_MUX_ENUM: D2_RS2=0, D2_IMM=1.
- cmp_op  in  3  ALU_CMP_OP_ENUM code.
- branch_jump  in  1  unconditional jump (JAL/JALR).
- alu_result  out  XLEN  ALU result; also the branch/jump target.
- branch  out  2  next-PC select: NOP=2'b00 (pc+4), BRANCH=2'b01 (taken conditional), JUMP=2'b10 (unconditional), 2'b11 reserved and never driven.

Behaviour:
- ALU_OP_ENUM encodings:
  - NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5.
  - SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10.
  - Codes 11-15 are illegal.
- ALU_CMP_OP_ENUM encodings: NOP=0, EQ=1, NE=2, LT=3, GE=4, LTU=5, GEU=6; code 7 is illegal.
- Operand selection: op1 = alu_data1_sel ? pc : rs1_data; op2 = alu_data2_sel ? immediate : rs2_data.
- ALU results:
  - ADD/SUB: modulo 2^XLEN; no overflow or carry flag.
  - AND/OR/XOR: bitwise.
  - Shift amount is op2[4:0] only; upper bits ignored.
  - SLL: logical left. SRL: logical right, zero fill. SRA: arithmetic right, fills with op1[31].
  - SLT: 1 if $signed(op1) < $signed(op2), else 0. SLTU: unsigned compare, same 1/0 result.
  - NOP and illegal codes: result 0.
- Branch compare always uses rs1_data vs rs2_data, never the muxed operands:
  - EQ: equal. NE: not equal.
  - LT/GE: signed compare. LTU/GEU: unsigned compare.
  - NOP and illegal codes: condition false.
- branch priority:
  - branch_jump=1 gives JUMP, regardless of cmp_op.
  - Otherwise a true condition gives BRANCH.
  - Otherwise NOP.
- Timing: all outputs purely combinational from the inputs, zero cycles latency, valid within the same cycle. No internal state and no handshake.
- Reset: while rst_n=1, alu_result=0 and branch=NOP, asynchronously and regardless of the other inputs. On deassertion, outputs follow the inputs immediately.
- No X propagation on outputs for any defined input code.

Test Plan:
- Reset held, rs1=100, rs2=4, alu_op=ADD, branch_jump=1 -> alu_result=0, branch=00. Release reset -> alu_result=104, branch=10.
- rs1=100, rs2=4, RS1/RS2 selects, cmp NOP, branch_jump=0 -> branch=00 for every op. Expected results:
  - ADD 104, SUB 96, AND 4, OR 100, XOR 96.
  - SLL 1600, SRL 6, SRA 6, SLTU 0, SLT 0.
  - NOP 0.
- Signed/unsigned split, rs1=0xFFFFFFF0, rs2=4:
  - SRA -> 0xFFFFFFFF; SRL -> 0x0FFFFFFF.
  - SLT -> 1; SLTU -> 0.
  - rs2=36 with SLL -> shift by 4.
- Mux, ADD, rs1=100, rs2=4, imm=10, pc=20:
  - RS1+IMM -> 110.
  - PC+IMM -> 30.
  - PC+RS2 -> 24.
- Branch, branch_jump=0:
  - rs1=rs2=5: EQ -> 01, NE -> 00.
  - rs1=-1, rs2=1: LT -> 01, LTU -> 00, GEU -> 01.
  - cmp NOP -> 00.
  - Then branch_jump=1 with cmp NE false -> 10.
- Illegal codes: alu_op=15 -> alu_result 0; cmp_op=7 -> branch 00.

Source files
------------

// File: rtl/alu_cmp_mux_enum_if.sv
// Execute-stage bus: operands, operation codes and the resulting ALU value / next-PC select.
interface alu_cmp_mux_enum_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] immediate;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic            alu_data1_sel;
    logic            alu_data2_sel;
    logic [2:0]      cmp_op;
    logic            branch_jump;
    logic [XLEN-1:0] alu_result;
    logic [1:0]      branch;

    // Decode stage side: drives operands and codes, consumes the results.
    modport master (
        output rs1_data, rs2_data, immediate, pc, alu_op,
               alu_data1_sel, alu_data2_sel, cmp_op, branch_jump,
        input  alu_result, branch
    );

    // Execute stage side.
    modport slave (
        input  rs1_data, rs2_data, immediate, pc, alu_op,
               alu_data1_sel, alu_data2_sel, cmp_op, branch_jump,
        output alu_result, branch
    );
endinterface

// File: rtl/alu_cmp_mux_enum.sv
// Execute-stage datapath: operand muxing, ALU and branch-condition evaluation.
// Fully combinational; reset only forces the outputs to their idle values.
module alu_cmp_mux_enum #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,   // active-high despite the name
    alu_cmp_mux_enum_if.slave   bus
);
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_NOP = 3'd0,
        CMP_EQ  = 3'd1,
        CMP_NE  = 3'd2,
        CMP_LT  = 3'd3,
        CMP_GE  = 3'd4,
        CMP_LTU = 3'd5,
        CMP_GEU = 3'd6
    } cmp_op_e;

    localparam logic [1:0] BR_NOP    = 2'b00;
    localparam logic [1:0] BR_BRANCH = 2'b01;
    localparam logic [1:0] BR_JUMP   = 2'b10;

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic            w_cond;
    logic [1:0]      w_branch;
    logic            w_unused_clk;

    // The clock only exists for pipeline uniformity.
    assign w_unused_clk = clk;

    // Operand selection and ALU result.
    always_comb begin
        w_op1   = bus.alu_data1_sel ? bus.pc        : bus.rs1_data;
        w_op2   = bus.alu_data2_sel ? bus.immediate : bus.rs2_data;
        w_shamt = w_op2[4:0];
        w_alu   = '0;
        case (bus.alu_op)
            ALU_ADD:  w_alu = w_op1 + w_op2;
            ALU_SUB:  w_alu = w_op1 - w_op2;
            ALU_AND:  w_alu = w_op1 & w_op2;
            ALU_OR:   w_alu = w_op1 | w_op2;
            ALU_XOR:  w_alu = w_op1 ^ w_op2;
            ALU_SLL:  w_alu = w_op1 << w_shamt;
            ALU_SRL:  w_alu = w_op1 >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(w_op1) >>> w_shamt);
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
            default:  w_alu = '0;
        endcase
    end

    // Branch condition on the raw register operands, then next-PC select priority.
    always_comb begin
        w_cond = 1'b0;
        case (bus.cmp_op)
            CMP_EQ:  w_cond = (bus.rs1_data == bus.rs2_data);
            CMP_NE:  w_cond = (bus.rs1_data != bus.rs2_data);
            CMP_LT:  w_cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            CMP_GE:  w_cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            CMP_LTU: w_cond = (bus.rs1_data <  bus.rs2_data);
            CMP_GEU: w_cond = (bus.rs1_data >= bus.rs2_data);
            default: w_cond = 1'b0;
        endcase
        if (bus.branch_jump)
            w_branch = BR_JUMP;
        else if (w_cond)
            w_branch = BR_BRANCH;
        else
            w_branch = BR_NOP;
    end

    // Reset masks the outputs asynchronously; no state to clear.
    always_comb begin
        if (rst_n) begin
            bus.alu_result = '0;
            bus.branch     = BR_NOP;
        end else begin
            bus.alu_result = w_alu;
            bus.branch     = w_branch;
        end
    end
endmodule

// File: tb/tb_alu_cmp_mux_enum.sv
// Self-checking bench for alu_cmp_mux_enum: scoreboard queue of expected outputs.
module tb_alu_cmp_mux_enum;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmp_mux_enum_if #(.XLEN(XLEN)) bus ();

    alu_cmp_mux_enum #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [1:0]  br;
    } exp_t;

    exp_t sb[$];

    // Drive one input vector and queue the result the bench expects for it.
    task automatic drive(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pcv, input logic [3:0] op,
                         input logic s1, input logic s2, input logic [2:0] cmp, input logic bj,
                         input logic [31:0] eres, input logic [1:0] ebr);
        exp_t e;
        @(negedge clk);
        bus.rs1_data      = rs1;
        bus.rs2_data      = rs2;
        bus.immediate     = imm;
        bus.pc            = pcv;
        bus.alu_op        = op;
        bus.alu_data1_sel = s1;
        bus.alu_data2_sel = s2;
        bus.cmp_op        = cmp;
        bus.branch_jump   = bj;
        e.name = name;
        e.res  = eres;
        e.br   = ebr;
        sb.push_back(e);
    endtask

    // Reference ALU, written independently of the RTL.
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'd1: r = a + b;
            4'd2: r = a + ~b + 32'd1;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0}; end
            4'd7: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]}; end
            4'd8: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]}; end
            4'd9: r = {31'd0, ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))};
            4'd10: r = {31'd0, (a < b)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] model_br(input logic [2:0] cmp, input logic [31:0] a,
                                            input logic [31:0] b, input logic bj);
        logic c;
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (cmp)
            3'd1: c = (a == b);
            3'd2: c = (a != b);
            3'd3: c = slt;
            3'd4: c = !slt;
            3'd5: c = (a < b);
            3'd6: c = !(a < b);
            default: c = 1'b0;
        endcase
        if (bj) return 2'b10;
        return c ? 2'b01 : 2'b00;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1;
        drive("rst_hold", 32'd100, 32'd4, 32'd0, 32'd0, 4'd1, 1'b0, 1'b0, 3'd0, 1'b1,
              32'd0, 2'b00);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.alu_result !== e.res) begin
            errors++;
            $display("FAIL %s alu_result: got %h expected %h", e.name, bus.alu_result, e.res);
        end
        checks++;
        if (bus.branch !== e.br) begin
            errors++;
            $display("FAIL %s branch: got %b expected %b", e.name, bus.branch, e.br);
        end
        // Release reset between clock edges: outputs must follow immediately.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.alu_result !== 32'd104) begin
            errors++;
            $display("FAIL rst_release alu_result: got %h expected %h", bus.alu_result, 32'd104);
        end
        checks++;
        if (bus.branch !== 2'b10) begin
            errors++;
            $display("FAIL rst_release branch: got %b expected %b", bus.branch, 2'b10);
        end
        // Reassert asynchronously mid-cycle, then release again.
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.alu_result !== 32'd0 || bus.branch !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got %h/%b expected 0/00", bus.alu_result, bus.branch);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_alu_ops();
        exp_t e;
        logic [3:0]  ops [11];
        logic [31:0] res [11];
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd9, 4'd0};
        res = '{32'd104, 32'd96, 32'd4, 32'd100, 32'd96, 32'd1600, 32'd6, 32'd6,
                32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 11; i++) begin
            drive($sformatf("alu_op%0d", ops[i]), 32'd100, 32'd4, 32'd0, 32'd0, ops[i],
                  1'b0, 1'b0, 3'd0, 1'b0, res[i], 2'b00);
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.alu_result !== e.res || bus.branch !== e.br) begin
                errors++;
                $display("FAIL %s: got %h/%b expected %h/%b", e.name, bus.alu_result,
                         bus.branch, e.res, e.br);
            end
        end
    endtask

    task automatic test_signed();
        exp_t e;
        logic [3:0]  ops [5];
        logic [31:0] rs2 [5];
        logic [31:0] res [5];
        ops = '{4'd8, 4'd7, 4'd9, 4'd10, 4'd6};
        rs2 = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd36};
        res = '{32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FF00};
        for (int i = 0; i < 5; i++) begin
            drive($sformatf("signed_op%0d", ops[i]), 32'hFFFF_FFF0, rs2[i], 32'd0, 32'd0,
                  ops[i], 1'b0, 1'b0, 3'd0, 1'b0, res[i], 2'b00);
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.alu_result !== e.res) begin
                errors++;
                $display("FAIL %s alu_result: got %h expected %h", e.name, bus.alu_result, e.res);
            end
        end
    endtask

    task automatic test_mux();
        exp_t e;
        logic        s1 [3];
        logic        s2 [3];
        logic [31:0] res [3];
        s1  = '{1'b0, 1'b1, 1'b1};
        s2  = '{1'b1, 1'b1, 1'b0};
        res = '{32'd110, 32'd30, 32'd24};
        for (int i = 0; i < 3; i++) begin
            drive($sformatf("mux_%0d%0d", s1[i], s2[i]), 32'd100, 32'd4, 32'd10, 32'd20,
                  4'd1, s1[i], s2[i], 3'd0, 1'b0, res[i], 2'b00);
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.alu_result !== e.res) begin
                errors++;
                $display("FAIL %s alu_result: got %h expected %h", e.name, bus.alu_result, e.res);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [31:0] a   [7];
        logic [31:0] b   [7];
        logic [2:0]  cmp [7];
        logic        bj  [7];
        logic [1:0]  br  [7];
        a   = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
        b   = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5};
        cmp = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0, 3'd2};
        bj  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        br  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 7; i++) begin
            // Muxed operands point elsewhere to show the compare ignores them.
            drive($sformatf("branch_cmp%0d_bj%0d", cmp[i], bj[i]), a[i], b[i], 32'd7,
                  32'd9, 4'd0, 1'b1, 1'b1, cmp[i], bj[i], 32'd0, br[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.branch !== e.br) begin
                errors++;
                $display("FAIL %s branch: got %b expected %b", e.name, bus.branch, e.br);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        drive("illegal_alu15", 32'd100, 32'd4, 32'd0, 32'd0, 4'd15, 1'b0, 1'b0, 3'd0, 1'b0,
              32'd0, 2'b00);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.alu_result !== e.res) begin
            errors++;
            $display("FAIL %s alu_result: got %h expected %h", e.name, bus.alu_result, e.res);
        end
        drive("illegal_cmp7_eq", 32'd5, 32'd5, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 3'd7, 1'b0,
              32'd0, 2'b00);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.branch !== e.br) begin
            errors++;
            $display("FAIL %s branch: got %b expected %b", e.name, bus.branch, e.br);
        end
        drive("illegal_cmp7_ne", 32'd5, 32'd6, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 3'd7, 1'b0,
              32'd0, 2'b00);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.branch !== e.br) begin
            errors++;
            $display("FAIL %s branch: got %b expected %b", e.name, bus.branch, e.br);
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [31:0] a, b, imm, pcv, op1, op2;
        logic [3:0]  op;
        logic [2:0]  cmp;
        logic        s1, s2, bj;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom();
            b   = (i % 4 == 0) ? a : $urandom();
            imm = $urandom();
            pcv = $urandom();
            op  = 4'($urandom_range(0, 15));
            cmp = 3'($urandom_range(0, 7));
            s1  = 1'($urandom_range(0, 1));
            s2  = 1'($urandom_range(0, 1));
            bj  = ($urandom_range(0, 3) == 0);
            op1 = s1 ? pcv : a;
            op2 = s2 ? imm : b;
            drive($sformatf("rand%0d_op%0d_cmp%0d", i, op, cmp), a, b, imm, pcv, op, s1, s2,
                  cmp, bj, model_alu(op, op1, op2), model_br(cmp, a, b, bj));
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.alu_result !== e.res || bus.branch !== e.br) begin
                errors++;
                $display("FAIL %s: got %h/%b expected %h/%b", e.name, bus.alu_result,
                         bus.branch, e.res, e.br);
            end
        end
    endtask

    initial begin
        rst_n             = 1'b1;
        bus.rs1_data      = '0;
        bus.rs2_data      = '0;
        bus.immediate     = '0;
        bus.pc            = '0;
        bus.alu_op        = '0;
        bus.alu_data1_sel = 1'b0;
        bus.alu_data2_sel = 1'b0;
        bus.cmp_op        = '0;
        bus.branch_jump   = 1'b0;
        test_reset();
        test_alu_ops();
        test_signed();
        test_mux();
        test_branch();
        test_illegal();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
